// File: rtl/blvds_link_supervisor.sv
// -----------------------------------------------------------------------------
// blvds_link_supervisor
//
// Recovery sequencer for the BLVDS frame receiver. It pulses the receiver reset
// for RST_LEN cycles, waits up to SYNC_TIMEOUT cycles for the first good frame,
// then watches error pulses over back-to-back WINDOW-cycle windows while the
// link is up. Repeated failed recoveries escalate to a latched FAULT that only
// the host can clear.
//
// Ports:
//   iCLK                 system clock, rising edge
//   iRST                 asynchronous active-high reset
//   iFULL_ERROR          single-cycle receiver error pulse
//   iHEAD_ERROR          single-cycle receiver error pulse
//   iEPILOG_ERROR        single-cycle receiver error pulse
//   iFRAME_OK            single-cycle pulse per good frame
//   iCLR_FAULT           host request to leave FAULT (level or pulse)
//   oRST_BLVDS_RECEIVER  reset to the receiver (high in RESET and FAULT)
//   oLINK_UP             high in UP
//   oFAULT               high in FAULT
//   oSTATE               RESET=0, SYNC=1, UP=2, FAULT=3
//   oRETRY_CNT           consecutive failed recovery attempts
//   oRECOVERY_CNT        total failure-caused recoveries, saturating
// -----------------------------------------------------------------------------
module blvds_link_supervisor #(
    parameter logic [15:0] RST_LEN      = 16'd16,
    parameter logic [15:0] SYNC_TIMEOUT = 16'd4096,
    parameter logic [15:0] WINDOW       = 16'd50000,
    parameter logic [15:0] ERR_NUM      = 16'd5,
    parameter logic [7:0]  MAX_RETRY    = 8'd3
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFULL_ERROR,
    input  logic        iHEAD_ERROR,
    input  logic        iEPILOG_ERROR,
    input  logic        iFRAME_OK,
    input  logic        iCLR_FAULT,
    output logic        oRST_BLVDS_RECEIVER,
    output logic        oLINK_UP,
    output logic        oFAULT,
    output logic [1:0]  oSTATE,
    output logic [7:0]  oRETRY_CNT,
    output logic [15:0] oRECOVERY_CNT
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_SYNC  = 2'd1,
        ST_UP    = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  err_q;
    logic        frame_ok_q;
    logic        clr_fault_q;
    logic [15:0] timer_q;
    logic [15:0] win_q;
    logic [15:0] errcnt_q;
    logic [7:0]  retry_q;
    logic [15:0] recov_q;

    logic [1:0]  err_pop_d;
    logic [16:0] err_sum_d;
    logic [15:0] errcnt_acc_d;
    logic [15:0] recov_inc_d;
    logic        fail_d;
    logic        win_last_d;

    always_comb begin
        err_pop_d    = {1'b0, err_q[0]} + {1'b0, err_q[1]} + {1'b0, err_q[2]};
        err_sum_d    = {1'b0, errcnt_q} + {15'd0, err_pop_d};
        errcnt_acc_d = err_sum_d[16] ? '1 : err_sum_d[15:0];
        recov_inc_d  = (recov_q == '1) ? recov_q : recov_q + 16'd1;
        win_last_d   = (win_q == WINDOW - 16'd1);
        fail_d       = 1'b0;
        case (state_q)
            // an error beats a simultaneous frame-OK; timeout only when neither
            ST_SYNC: fail_d = (|err_q) ||
                              (!frame_ok_q && (timer_q == SYNC_TIMEOUT - 16'd1));
            ST_UP:   fail_d = (errcnt_q > ERR_NUM);
            default: fail_d = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= ST_RESET;
            err_q       <= '0;
            frame_ok_q  <= 1'b0;
            clr_fault_q <= 1'b0;
            timer_q     <= '0;
            win_q       <= '0;
            errcnt_q    <= '0;
            retry_q     <= '0;
            recov_q     <= '0;
        end else begin
            err_q       <= {iFULL_ERROR, iHEAD_ERROR, iEPILOG_ERROR};
            frame_ok_q  <= iFRAME_OK;
            clr_fault_q <= iCLR_FAULT;

            if (fail_d) begin
                // a trip also takes priority over a coinciding window boundary
                recov_q <= recov_inc_d;
                timer_q <= '0;
                if (retry_q == MAX_RETRY) begin
                    state_q <= ST_FAULT;
                end else begin
                    retry_q <= retry_q + 8'd1;
                    state_q <= ST_RESET;
                end
            end else begin
                case (state_q)
                    ST_RESET: begin
                        if (timer_q == RST_LEN - 16'd1) begin
                            state_q <= ST_SYNC;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 16'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (frame_ok_q) begin
                            state_q  <= ST_UP;
                            timer_q  <= '0;
                            win_q    <= '0;
                            errcnt_q <= '0;
                        end else begin
                            timer_q <= timer_q + 16'd1;
                        end
                    end
                    ST_UP: begin
                        // clearing the retry count at every clean boundary is
                        // equivalent to clearing it at the first one: it stays
                        // zero until the link leaves UP
                        if (win_last_d) begin
                            errcnt_q <= {14'd0, err_pop_d};
                            win_q    <= '0;
                            retry_q  <= '0;
                        end else begin
                            errcnt_q <= errcnt_acc_d;
                            win_q    <= win_q + 16'd1;
                        end
                    end
                    ST_FAULT: begin
                        if (clr_fault_q) begin
                            state_q <= ST_RESET;
                            timer_q <= '0;
                            retry_q <= '0;
                        end
                    end
                    default: state_q <= ST_RESET;
                endcase
            end
        end
    end

    always_comb begin
        oRST_BLVDS_RECEIVER = (state_q == ST_RESET) || (state_q == ST_FAULT);
        oLINK_UP            = (state_q == ST_UP);
        oFAULT              = (state_q == ST_FAULT);
        oSTATE              = state_q;
        oRETRY_CNT          = retry_q;
        oRECOVERY_CNT       = recov_q;
    end

endmodule

// File: tb/tb_blvds_link_supervisor.sv
// -----------------------------------------------------------------------------
// tb_blvds_link_supervisor
//
// Randomized bench for blvds_link_supervisor. Stimulus runs in segments with
// different traffic profiles (clean link, sparse errors, error bursts, no
// frames at all, frame/error clashes) plus occasional asynchronous resets. A
// behavioural model tracks link state by time spent in each state and compares
// every output on each falling edge.
// -----------------------------------------------------------------------------
module tb_blvds_link_supervisor;

    localparam int RL  = 4;
    localparam int STO = 100;
    localparam int WIN = 1000;
    localparam int EN  = 5;
    localparam int MR  = 3;

    logic        iCLK;
    logic        iRST;
    logic        iFULL_ERROR;
    logic        iHEAD_ERROR;
    logic        iEPILOG_ERROR;
    logic        iFRAME_OK;
    logic        iCLR_FAULT;
    logic        oRST_BLVDS_RECEIVER;
    logic        oLINK_UP;
    logic        oFAULT;
    logic [1:0]  oSTATE;
    logic [7:0]  oRETRY_CNT;
    logic [15:0] oRECOVERY_CNT;

    blvds_link_supervisor #(
        .RST_LEN      (16'd4),
        .SYNC_TIMEOUT (16'd100),
        .WINDOW       (16'd1000),
        .ERR_NUM      (16'd5),
        .MAX_RETRY    (8'd3)
    ) dut (
        .iCLK                (iCLK),
        .iRST                (iRST),
        .iFULL_ERROR         (iFULL_ERROR),
        .iHEAD_ERROR         (iHEAD_ERROR),
        .iEPILOG_ERROR       (iEPILOG_ERROR),
        .iFRAME_OK           (iFRAME_OK),
        .iCLR_FAULT          (iCLR_FAULT),
        .oRST_BLVDS_RECEIVER (oRST_BLVDS_RECEIVER),
        .oLINK_UP            (oLINK_UP),
        .oFAULT              (oFAULT),
        .oSTATE              (oSTATE),
        .oRETRY_CNT          (oRETRY_CNT),
        .oRECOVERY_CNT       (oRECOVERY_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_state: 0 reset-pulse, 1 waiting for first frame, 2 link up, 3 fault
    // m_age:   cycles already spent in the current state
    int m_state, m_age, m_errs, m_retry, m_recov;
    int d_err, d_ok, d_clr;   // inputs as seen one cycle late

    task automatic go(input int s);
        m_state = s;
        m_age   = 0;
    endtask

    task automatic model_fail();
        m_recov = (m_recov < 65535) ? m_recov + 1 : 65535;
        if (m_retry == MR) go(3);
        else begin
            m_retry++;
            go(0);
        end
    endtask

    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            m_state = 0; m_age = 0; m_errs = 0; m_retry = 0; m_recov = 0;
            d_err = 0; d_ok = 0; d_clr = 0;
        end else begin
            case (m_state)
                0: if (m_age + 1 == RL) go(1); else m_age++;
                1: begin
                    if (d_err > 0) model_fail();
                    else if (d_ok != 0) begin
                        go(2);
                        m_errs = 0;
                    end
                    else if (m_age + 1 == STO) model_fail();
                    else m_age++;
                end
                2: begin
                    if (m_errs > EN) model_fail();
                    else begin
                        if (m_age % WIN == WIN - 1) begin
                            m_errs  = d_err;
                            m_retry = 0;
                        end else begin
                            m_errs = (m_errs + d_err > 65535) ? 65535 : m_errs + d_err;
                        end
                        m_age++;
                    end
                end
                default: if (d_clr != 0) begin
                    go(0);
                    m_retry = 0;
                end
            endcase
            d_err = $countones({iFULL_ERROR, iHEAD_ERROR, iEPILOG_ERROR});
            d_ok  = int'(iFRAME_OK);
            d_clr = int'(iCLR_FAULT);
        end
    end

    task automatic compare_all();
        chk("state",    {30'd0, oSTATE},              m_state);
        chk("rst_rx",   {31'd0, oRST_BLVDS_RECEIVER}, (m_state == 0 || m_state == 3) ? 1 : 0);
        chk("link_up",  {31'd0, oLINK_UP},            (m_state == 2) ? 1 : 0);
        chk("fault",    {31'd0, oFAULT},              (m_state == 3) ? 1 : 0);
        chk("retry",    {24'd0, oRETRY_CNT},          m_retry);
        chk("recovery", {16'd0, oRECOVERY_CNT},       m_recov);
    endtask

    task automatic compare_reset_values(input string pfx);
        chk({pfx, "_state"},    {30'd0, oSTATE},              0);
        chk({pfx, "_rst_rx"},   {31'd0, oRST_BLVDS_RECEIVER}, 1);
        chk({pfx, "_link_up"},  {31'd0, oLINK_UP},            0);
        chk({pfx, "_fault"},    {31'd0, oFAULT},              0);
        chk({pfx, "_retry"},    {24'd0, oRETRY_CNT},          0);
        chk({pfx, "_recovery"}, {16'd0, oRECOVERY_CNT},       0);
    endtask

    function automatic bit chance(input int per_mille);
        return $urandom_range(0, 999) < per_mille;
    endfunction

    int mode, seg_len, cyc;
    int p_ok, p_err, p_burst, p_clr;

    initial begin
        iRST = 1'b1;
        iFULL_ERROR = 1'b0; iHEAD_ERROR = 1'b0; iEPILOG_ERROR = 1'b0;
        iFRAME_OK = 1'b0; iCLR_FAULT = 1'b0;
        repeat (2) @(negedge iCLK);
        compare_reset_values("por");
        iRST = 1'b0;
        cyc = 0;

        while (cyc < 40000) begin
            mode    = int'($urandom_range(0, 4));
            seg_len = int'($urandom_range(200, 1500));
            case (mode)
                0:       begin p_ok = 50;  p_err = 0;  p_burst = 0;  p_clr = 5; end
                1:       begin p_ok = 50;  p_err = 2;  p_burst = 1;  p_clr = 5; end
                2:       begin p_ok = 50;  p_err = 15; p_burst = 10; p_clr = 5; end
                3:       begin p_ok = 0;   p_err = 0;  p_burst = 0;  p_clr = 3; end
                default: begin p_ok = 100; p_err = 30; p_burst = 5;  p_clr = 5; end
            endcase
            for (int i = 0; i < seg_len; i++) begin
                @(negedge iCLK);
                cyc++;
                compare_all();
                if (iRST) iRST = 1'b0;
                iFRAME_OK  = chance(p_ok);
                iCLR_FAULT = chance(p_clr);
                if (chance(p_burst)) begin
                    iFULL_ERROR = 1'b1; iHEAD_ERROR = 1'b1; iEPILOG_ERROR = 1'b1;
                end else begin
                    iFULL_ERROR   = chance(p_err);
                    iHEAD_ERROR   = chance(p_err);
                    iEPILOG_ERROR = chance(p_err);
                end
                if (chance(1) && $urandom_range(0, 7) == 0) begin
                    #3 iRST = 1'b1;
                    #1 compare_reset_values("async_rst");
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
